// File: rtl/arbitro_memoria_if.sv
// arbitro_memoria_if: CPU, video and RAM bus bundle for the memory arbiter.
// Signals keep the names of the arbiter's bus ports.
// Modports:
//   slave  - the arbiter: takes requests and memDatoIn, drives grants, read data and RAM controls.
//   master - the surroundings: CPU, video fetch and RAM.
interface arbitro_memoria_if #(parameter int ANCHO_DATO = 32, parameter int ANCHO_DIREC = 32);
  logic                   cpuReq;
  logic                   cpuWr;
  logic [ANCHO_DIREC-1:0] cpuDirec;
  logic [ANCHO_DATO-1:0]  cpuDatoIn;
  logic [ANCHO_DATO-1:0]  cpuDatoOut;
  logic                   cpuStall;
  logic                   vidReq;
  logic [ANCHO_DIREC-1:0] vidDirec;
  logic                   vidGnt;
  logic                   vidValid;
  logic [ANCHO_DATO-1:0]  vidDatoOut;
  logic [ANCHO_DIREC-1:0] memDirec;
  logic [ANCHO_DATO-1:0]  memDatoOut;
  logic                   memWr;
  logic [ANCHO_DATO-1:0]  memDatoIn;
  modport slave (
    input  cpuReq, cpuWr, cpuDirec, cpuDatoIn, vidReq, vidDirec, memDatoIn,
    output cpuDatoOut, cpuStall, vidGnt, vidValid, vidDatoOut, memDirec, memDatoOut, memWr
  );
  modport master (
    output cpuReq, cpuWr, cpuDirec, cpuDatoIn, vidReq, vidDirec, memDatoIn,
    input  cpuDatoOut, cpuStall, vidGnt, vidValid, vidDatoOut, memDirec, memDatoOut, memWr
  );
endinterface

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: shares one single-port synchronous RAM between a CPU load/store port and a read-only video fetch port.
// Ports: clk, rst (asynchronous, active high), bus (arbitro_memoria_if.slave: CPU, video and RAM signals).
// Optional macro ARBITRO_ANTIHAMBRE_EN adds an anti-starvation counter that forces a video grant
// after MAX_ESPERA consecutive denied video cycles; without it the CPU has strict priority.
module arbitro_memoria #(
  parameter int ANCHO_DATO  = 32,
  parameter int ANCHO_DIREC = 32,
  parameter int MAX_ESPERA  = 4
) (
  input logic              clk,
  input logic              rst,
  arbitro_memoria_if.slave bus
);
  typedef enum logic [1:0] {NINGUNO, DATO_CPU, DATO_VID} fase_t;
  localparam logic [ANCHO_DATO-1:0]  CERO_D = '0;
  localparam logic [ANCHO_DIREC-1:0] CERO_A = '0;
  fase_t fase_q, fase_d;
  logic  cpu_eleg, forzado, gnt_vid, gnt_cpu, esc_cpu;
  // a stalled CPU keeps its request up during its own data phase, so that cycle must not re-issue it
  assign cpu_eleg = bus.cpuReq && fase_q != DATO_CPU;
  assign gnt_vid  = bus.vidReq && (!cpu_eleg || forzado);
  assign gnt_cpu  = cpu_eleg && !gnt_vid;
  assign esc_cpu  = gnt_cpu && bus.cpuWr;
  assign fase_d   = gnt_vid ? DATO_VID : (gnt_cpu && !bus.cpuWr) ? DATO_CPU : NINGUNO;
  assign bus.memDirec   = gnt_vid ? bus.vidDirec : gnt_cpu ? bus.cpuDirec : CERO_A;
  assign bus.memWr      = esc_cpu;
  assign bus.memDatoOut = esc_cpu ? bus.cpuDatoIn : CERO_D;
  assign bus.vidGnt     = gnt_vid;
  assign bus.cpuStall   = cpu_eleg && !esc_cpu;
  assign bus.cpuDatoOut = fase_q == DATO_CPU ? bus.memDatoIn : CERO_D;
  assign bus.vidValid   = fase_q == DATO_VID;
  assign bus.vidDatoOut = fase_q == DATO_VID ? bus.memDatoIn : CERO_D;
  always_ff @(posedge clk or posedge rst)
    if (rst) fase_q <= NINGUNO;
    else     fase_q <= fase_d;
`ifdef ARBITRO_ANTIHAMBRE_EN
  localparam int CW = $clog2(MAX_ESPERA + 1);
  logic [CW-1:0] espera_q, espera_d;
  assign forzado  = espera_q >= CW'(MAX_ESPERA);
  // once saturated the next cycle with vidReq is a grant, which clears the count
  assign espera_d = (!bus.vidReq || gnt_vid) ? '0 : forzado ? espera_q : espera_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) espera_q <= '0;
    else     espera_q <= espera_d;
`else
  assign forzado = 1'b0;
`endif
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_arbitro_memoria;
`ifdef ARBITRO_ANTIHAMBRE_EN
  localparam bit ANTI = 1'b1;
`else
  localparam bit ANTI = 1'b0;
`endif
  localparam int MAXE = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tot_cnt = 0;
  int pass_cnt = 0;
  logic [31:0] ram [256];
  arbitro_memoria_if b ();
  arbitro_memoria #(.ANCHO_DATO(32), .ANCHO_DIREC(32), .MAX_ESPERA(MAXE)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b.memWr) ram[b.memDirec[7:0]] <= b.memDatoOut;
    b.memDatoIn <= ram[b.memDirec[7:0]];
  end
  task automatic drive(input logic req, input logic wr, input logic [31:0] dir, input logic [31:0] dato,
                       input logic vreq, input logic [31:0] vdir);
    b.cpuReq = req; b.cpuWr = wr; b.cpuDirec = dir; b.cpuDatoIn = dato; b.vidReq = vreq; b.vidDirec = vdir;
  endtask
  function automatic logic [165:0] salidas();
    return {b.cpuDatoOut, b.cpuStall, b.vidGnt, b.vidValid, b.vidDatoOut, b.memDirec, b.memDatoOut, b.memWr};
  endfunction
  task automatic test_reset();
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 0); #1;
    tot_cnt++; if (salidas() !== '0) $display("FAIL reset_outputs: got %h expected 0", salidas()); else pass_cnt++;
    @(negedge clk); rst = 1'b0; #1;
    tot_cnt++; if (salidas() !== '0) $display("FAIL idle_outputs: got %h expected 0", salidas()); else pass_cnt++;
  endtask
  task automatic test_cpu_read();
    @(negedge clk); drive(1, 0, 32'h10, 0, 0, 0); #1;
    tot_cnt++; if (b.cpuStall !== 1'b1) $display("FAIL rd_issue_stall: got %b expected 1", b.cpuStall); else pass_cnt++;
    tot_cnt++; if (b.memDirec !== 32'h10) $display("FAIL rd_issue_addr: got %h expected 10", b.memDirec); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++; if (b.cpuStall !== 1'b0) $display("FAIL rd_data_stall: got %b expected 0", b.cpuStall); else pass_cnt++;
    tot_cnt++; if (b.cpuDatoOut !== 32'hCAFE0001) $display("FAIL rd_data: got %h expected cafe0001", b.cpuDatoOut); else pass_cnt++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_cpu_write();
    @(negedge clk); drive(1, 1, 32'h20, 32'h0000ABCD, 0, 0); #1;
    tot_cnt++; if ({b.memWr, b.cpuStall} !== 2'b10) $display("FAIL wr_grant: got memWr/stall %b expected 10", {b.memWr, b.cpuStall}); else pass_cnt++;
    tot_cnt++; if (b.memDatoOut !== 32'h0000ABCD) $display("FAIL wr_data: got %h expected 0000abcd", b.memDatoOut); else pass_cnt++;
    @(negedge clk); drive(1, 0, 32'h20, 0, 0, 0); #1;
    tot_cnt++; if ({b.memWr, b.cpuStall} !== 2'b01) $display("FAIL wr_one_cycle: got memWr/stall %b expected 01", {b.memWr, b.cpuStall}); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++; if (b.cpuDatoOut !== 32'h0000ABCD) $display("FAIL wr_readback: got %h expected 0000abcd", b.cpuDatoOut); else pass_cnt++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_simultaneo();
    @(negedge clk); drive(1, 0, 32'h10, 0, 1, 32'h40); #1;
    tot_cnt++; if ({b.vidGnt, b.cpuStall, b.memDirec} !== {2'b01, 32'h10}) $display("FAIL sim_c0: got gnt/stall/addr %h expected 1_00000010", {b.vidGnt, b.cpuStall, b.memDirec}); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++; if ({b.vidGnt, b.cpuStall, b.memDirec} !== {2'b10, 32'h40}) $display("FAIL sim_c1: got gnt/stall/addr %h expected 2_00000040", {b.vidGnt, b.cpuStall, b.memDirec}); else pass_cnt++;
    tot_cnt++; if (b.cpuDatoOut !== 32'hCAFE0001) $display("FAIL sim_c1_data: got %h expected cafe0001", b.cpuDatoOut); else pass_cnt++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
    tot_cnt++; if ({b.vidValid, b.vidDatoOut} !== {1'b1, 32'h55}) $display("FAIL sim_c2_vid: got %h expected 1_00000055", {b.vidValid, b.vidDatoOut}); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++; if (b.vidValid !== 1'b0) $display("FAIL sim_c3_novalid: got %b expected 0", b.vidValid); else pass_cnt++;
  endtask
  task automatic test_antihambre();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(1, 1, 32'h80 + i, i, 1, 32'h40); #1;
      if (ANTI && i <= 5) begin
        tot_cnt++;
        if ({b.vidGnt, b.cpuStall, b.memWr} !== (i == 4 ? 3'b110 : 3'b001))
          $display("FAIL antihambre_c%0d: got gnt/stall/wr %b expected %b", i, {b.vidGnt, b.cpuStall, b.memWr}, (i == 4 ? 3'b110 : 3'b001));
        else pass_cnt++;
      end else if (!ANTI) begin
        tot_cnt++;
        if ({b.vidGnt, b.memWr} !== 2'b01) $display("FAIL starve_c%0d: got gnt/wr %b expected 01", i, {b.vidGnt, b.memWr}); else pass_cnt++;
      end
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    @(negedge clk); drive(0, 0, 0, 0, 1, 32'h40); #1;
    tot_cnt++; if (b.vidGnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", b.vidGnt); else pass_cnt++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); rst = 1'b1; #1;
    tot_cnt++; if (salidas() !== '0) $display("FAIL rmid_vid_outputs: got %h expected 0", salidas()); else pass_cnt++;
    @(negedge clk); rst = 1'b0; drive(1, 0, 32'h10, 0, 0, 0); #1;
    tot_cnt++; if ({b.cpuStall, b.memDirec} !== {1'b1, 32'h10}) $display("FAIL rmid_cpu_issue: got %h expected 1_00000010", {b.cpuStall, b.memDirec}); else pass_cnt++;
    @(negedge clk); rst = 1'b1; #1;
    tot_cnt++; if ({b.cpuStall, b.cpuDatoOut, b.memDirec} !== {1'b1, 32'h0, 32'h10}) $display("FAIL rmid_cpu_reissue: got %h expected 1_00000000_00000010", {b.cpuStall, b.cpuDatoOut, b.memDirec}); else pass_cnt++;
    @(negedge clk); rst = 1'b0; #1;
    tot_cnt++; if ({b.cpuStall, b.memDirec} !== {1'b1, 32'h10}) $display("FAIL rmid_cpu_after: got %h expected 1_00000010", {b.cpuStall, b.memDirec}); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++; if ({b.cpuStall, b.cpuDatoOut} !== {1'b0, 32'hCAFE0001}) $display("FAIL rmid_cpu_data: got %h expected 0_cafe0001", {b.cpuStall, b.cpuDatoOut}); else pass_cnt++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_random();
    logic [31:0] sombra [256];
    int dueno = 0;
    int espera = 0;
    logic [31:0] pend = '0;
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin ram[i] = $urandom; sombra[i] = ram[i]; end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic req, wr, vreq, elig, vgana, cgana;
      logic [31:0] dir, dato, vdir;
      logic [97:0] e_bus;
      logic [64:0] e_dat;
      req = ($urandom_range(0, 3) != 0); wr = $urandom_range(0, 1); vreq = $urandom_range(0, 1);
      dir = $urandom_range(0, 255); vdir = $urandom_range(0, 255); dato = $urandom;
      drive(req, wr, dir, dato, vreq, vdir);
      elig  = req && dueno != 1;
      vgana = vreq && (!elig || (ANTI && espera >= MAXE));
      cgana = elig && !vgana;
      e_bus = {(vgana ? vdir : cgana ? dir : 32'h0), cgana && wr, (cgana && wr ? dato : 32'h0), vgana, elig && !(cgana && wr)};
      e_dat = {(dueno == 1 ? pend : 32'h0), dueno == 2, (dueno == 2 ? pend : 32'h0)};
      #1;
      tot_cnt++;
      if ({b.memDirec, b.memWr, b.memDatoOut, b.vidGnt, b.cpuStall} !== e_bus)
        $display("FAIL random_bus_%0d: got %h expected %h", n, {b.memDirec, b.memWr, b.memDatoOut, b.vidGnt, b.cpuStall}, e_bus);
      else pass_cnt++;
      tot_cnt++;
      if ({b.cpuDatoOut, b.vidValid, b.vidDatoOut} !== e_dat)
        $display("FAIL random_data_%0d: got %h expected %h", n, {b.cpuDatoOut, b.vidValid, b.vidDatoOut}, e_dat);
      else pass_cnt++;
      pend   = vgana ? sombra[vdir[7:0]] : sombra[dir[7:0]];
      dueno  = vgana ? 2 : (cgana && !wr) ? 1 : 0;
      espera = (!vreq || vgana) ? 0 : (espera < MAXE ? espera + 1 : MAXE);
      if (cgana && wr) sombra[dir[7:0]] = dato;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'hCAFE0001;
    ram[8'h40] = 32'h00000055;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_simultaneo();
    test_antihambre();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

- Shares the single-port synchronous data RAM between two requesters:
  - the microprocessor's load/store port (CPU);
  - a read-only video fetch port that pulls tile/sprite words.
- Sits between the processor and the data memory.
- Issues at most one access per cycle, tracks which requester owns the read data returning next cycle, and stalls the CPU while its access is pending or denied.
- CPU has priority; an optional anti-starvation counter guarantees video bandwidth.

## Interface
Parameters:
- ANCHO_DATO, 32, data word width
- ANCHO_DIREC, 32, address width
- MAX_ESPERA, 4, consecutive denied video cycles before video is forced (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpuReq  in  1  CPU requests an access this cycle
- cpuWr  in  1  1 = write, 0 = read (valid with cpuReq)
- cpuDirec  in  ANCHO_DIREC  CPU address
- cpuDatoIn  in  ANCHO_DATO  CPU write data
- cpuDatoOut  out  ANCHO_DATO  CPU read data (valid in CPU data phase)
- cpuStall  out  1  CPU must hold PC/instruction this cycle
- vidReq  in  1  video read request
- vidDirec  in  ANCHO_DIREC  video address
- vidGnt  out  1  video address accepted this cycle
- vidValid  out  1  vidDatoOut carries data for the access granted last cycle
- vidDatoOut  out  ANCHO_DATO  video read data
- memDirec  out  ANCHO_DIREC  RAM address
- memDatoOut  out  ANCHO_DATO  RAM write data
- memWr  out  1  RAM write enable
- memDatoIn  in  ANCHO_DATO  RAM read data, 1-cycle latency after address

## Operation
- State register `fase`: NINGUNO, DATO_CPU, DATO_VID.
  - Names the owner of memDatoIn in the current cycle.
  - Next fase = owner of the read issued this cycle, or NINGUNO if no read was issued.
- Address port is arbitrated every cycle, independent of fase.
- CPU is eligible when cpuReq=1 and fase≠DATO_CPU, because a stalled CPU still holds the same request during its data phase.
- Grant rule:
  - forced = anti-starvation asserted (see Configuration).
  - Video wins if vidReq=1 and (CPU not eligible or forced).
  - Otherwise CPU wins if eligible.
  - Otherwise no access is issued: memWr=0, memDirec=0.
- CPU write grant:
  - memDirec=cpuDirec, memDatoOut=cpuDatoIn, memWr=1, cpuStall=0.
  - Completes in 1 cycle; next fase is NINGUNO.
- CPU read grant:
  - memDirec=cpuDirec, cpuStall=1, next fase is DATO_CPU.
- Video grant:
  - memDirec=vidDirec, vidGnt=1, memWr=0, next fase is DATO_VID.
  - Back-to-back video grants are allowed.
- cpuStall is 1 whenever cpuReq=1 and the CPU is denied or is in its read-issue cycle.
  - cpuStall=0 in DATO_CPU and when cpuReq=0.
- Read-data outputs are zero-gated:
  - DATO_CPU: cpuDatoOut=memDatoIn.
  - DATO_VID: vidValid=1, vidDatoOut=memDatoIn.
  - Otherwise both are 0 and vidValid=0.
- memDatoOut=0 unless a CPU write is granted.

## Timing
- Reset: fase=NINGUNO, counter=0. With all inputs low, every output is 0.
- Reset mid-operation:
  - The pending data phase is discarded; no vidValid follows.
  - CPU remains stalled and reissues its access.
- Latency:
  - CPU write: 1 cycle.
  - CPU read: 2 cycles (issue, data), with no competing video.
  - Video: data arrives in the cycle after vidGnt.
- Simultaneous events:
  - In a DATO_CPU cycle with vidReq=1, video is granted; CPU data is delivered in the same cycle.
  - A CPU write and a video request in the same cycle go to the CPU unless forced.
- Outputs are combinational from fase, counter and the current inputs. Only fase and the counter are registered.

## Configuration
- ARBITRO_ANTIHAMBRE_EN defined:
  - Saturating counter, width $clog2(MAX_ESPERA+1).
  - Increments each cycle vidReq=1 and vidGnt=0; clears on vidGnt or vidReq=0.
  - forced = (counter ≥ MAX_ESPERA).
- Not defined: counter absent, forced=0, strict CPU priority. Video can starve indefinitely.

## Test plan
- Reset, then CPU read of 0x10 where RAM[0x10]=0xCAFE0001:
  - Cycle 0: cpuStall=1, memDirec=0x10.
  - Cycle 1: cpuStall=0, cpuDatoOut=0xCAFE0001.
- CPU write of 0x0000ABCD to 0x20, vidReq=0:
  - memWr=1 for exactly 1 cycle, cpuStall=0.
  - A following read of 0x20 returns 0x0000ABCD.
- CPU read of 0x10 together with video read of 0x40 (RAM=0x55):
  - Cycle 0: CPU issued.
  - Cycle 1: vidGnt=1, memDirec=0x40, CPU gets its data.
  - Cycle 2: vidValid=1, vidDatoOut=0x55.
- With the macro, MAX_ESPERA=4: continuous CPU writes with vidReq held → vidGnt=0 for cycles 0–3, vidGnt=1 at cycle 4 with cpuStall=1, CPU write re-granted at cycle 5.
- Same stimulus without the macro → vidGnt stays 0 for 20 cycles.
- Assert rst during DATO_VID → vidValid=0 the next cycle, fase=NINGUNO, all outputs 0 while inputs are low.
